// File: rtl/conv_pkg.sv
// Shared types and defaults for the conv layer sequencer and its phase timeout counter.
package conv_pkg;

    localparam int NUM_LAYERS_DEF  = 2;
    localparam int TIMEOUT_CYC_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_READ_MEM,
        ST_PE,
        ST_WR_RES,
        ST_DONE,
        ST_ERR
    } state_e;

    // $clog2 collapses to zero for a single layer or a disabled timeout; keep at least one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/conv_timeout.sv
// Saturating per-phase cycle counter; flags expiry on the last cycle a done may still arrive.
module conv_timeout
    import conv_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int               CNT_W   = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (TIMEOUT_CYC > 0) && enable && (cnt_q == LIMIT);

endmodule

// File: rtl/conv_seq_cu.sv
// Conv layer sequencer: per layer a memory read, a PE pass and a one-cycle result write,
// then a done pulse after the last layer. All outputs decode from state and layer index.
module conv_seq_cu
    import conv_pkg::*;
#(
    parameter int NUM_LAYERS  = NUM_LAYERS_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int IDX_W       = idx_width(NUM_LAYERS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] done_mem,
    input  logic [NUM_LAYERS-1:0] done_pe,
    output logic [NUM_LAYERS-1:0] start_mem,
    output logic [NUM_LAYERS-1:0] start_pe,
    output logic [NUM_LAYERS-1:0] wrmem_en,
    output logic [IDX_W-1:0]      layer_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_LAYERS-1:0] idx_oh;
    logic                  mem_hit, pe_hit, in_phase, phase_clear, phase_expired;

    // Only the active layer's done bit is looked at; every other bit is masked off.
    assign idx_oh      = NUM_LAYERS'(1) << idx_q;
    assign mem_hit     = |(done_mem & idx_oh);
    assign pe_hit      = |(done_pe & idx_oh);
    assign in_phase    = (state_q == ST_READ_MEM) || (state_q == ST_PE);
    assign phase_clear = (state_d != state_q);

    conv_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (phase_clear),
        .enable (in_phase),
        .expired(phase_expired)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    state_d = ST_ARM;
                    idx_d   = '0;
                end
            end
            ST_ARM:      if (!start) state_d = ST_READ_MEM;
            ST_READ_MEM: begin
                if (mem_hit)            state_d = ST_PE;
                else if (phase_expired) state_d = ST_ERR;
            end
            ST_PE: begin
                if (pe_hit)             state_d = ST_WR_RES;
                else if (phase_expired) state_d = ST_ERR;
            end
            ST_WR_RES: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_READ_MEM;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        // Abort beats any done or timeout seen in the same cycle and keeps the index.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            idx_d   = idx_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        start_mem = '0;
        start_pe  = '0;
        wrmem_en  = '0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            ST_ARM:      busy = 1'b1;
            ST_READ_MEM: begin
                busy      = 1'b1;
                start_mem = idx_oh;
            end
            ST_PE: begin
                busy     = 1'b1;
                start_pe = idx_oh;
            end
            ST_WR_RES: begin
                busy     = 1'b1;
                wrmem_en = idx_oh;
            end
            ST_DONE:     done = 1'b1;
            ST_ERR:      err  = 1'b1;
            default:     busy = 1'b0;
        endcase
    end

    assign layer_idx = idx_q;

endmodule
